// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, 8N1 frame constants and the baud divider helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Clock cycles per bit; callers keep the result within 8..65535.
  function automatic logic [15:0] calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned baud);
    int unsigned q;
    q = clk_freq / baud;
    return q[15:0];
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the synchronized samples.
// Edges are suppressed until three genuine post-reset samples exist, so a line already low at reset release never looks like a start bit.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic dout_sync,
  output logic fall_pulse
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [2:0] vld_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      vld_q  <= 3'b000;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      vld_q  <= {vld_q[1:0], 1'b1};
    end
  end

  assign dout_sync  = sync_q;
  assign fall_pulse = vld_q[2] & prev_q & ~sync_q;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver sampling each bit mid-period; UART_RECV_MAJORITY_EN selects a 3-sample majority vote per bit.
// uart_done / frame_err pulse one cycle after the stop-bit decision; no backpressure, uart_data is simply overwritten.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       uart_done,
  output logic [7:0] uart_data,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [15:0] BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] LAST_CNT = BPS_CNT - 16'd1;
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RECV_MAJORITY_EN
  // The vote resolves one cycle late; every later decision inherits that shift via the counter clear.
  localparam logic [15:0] START_CNT = (BPS_CNT >> 1) + 16'd1;
`else
  localparam logic [15:0] START_CNT = BPS_CNT >> 1;
`endif

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        rxd_sync;
  logic        fall_pulse;
  logic        bit_val;

  uart_rx_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .din        (uart_rxd),
    .dout_sync  (rxd_sync),
    .fall_pulse (fall_pulse)
  );

`ifdef UART_RECV_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) hist_q <= 2'b11;
    else            hist_q <= {hist_q[0], rxd_sync};
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_sync) | (hist_q[0] & rxd_sync);
`else
  assign bit_val = rxd_sync;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_pulse) begin
          state_d = ST_START;
          cnt_d   = 16'd0;
        end
      end
      ST_START: begin
        if (cnt_q == START_CNT) begin
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = bit_val ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d              = 16'd0;
          shift_d[bit_idx_q] = bit_val;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = 16'd0;
          if (bit_val) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_BREAK: begin
        if (rxd_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign uart_done = done_q;
  assign frame_err = ferr_q;
  assign uart_data = data_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv at 10 clocks per bit: directed vector table, corner sequences, random frames vs a frame-level model.
module tb_uart_recv;

  localparam int BIT_CYC = 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rxd  = 1'b1;
  logic       uart_done;
  logic       frame_err;
  logic       rx_busy;
  logic [7:0] uart_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];
  int         err_cnt   = 0;
  logic       done_prev = 1'b0;
  logic       ferr_prev = 1'b0;

  uart_recv #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: records every byte delivered and enforces single-cycle, mutually exclusive pulses.
  always @(negedge sys_clk) begin
    if (uart_done) begin
      obs_q.push_back(uart_data);
      obs_cyc_q.push_back(cyc);
      check("done_one_cycle", done_prev, 1'b0);
    end
    if (frame_err) begin
      err_cnt++;
      check("ferr_one_cycle", ferr_prev, 1'b0);
    end
    if (uart_done || frame_err) check("done_ferr_exclusive", uart_done & frame_err, 1'b0);
    done_prev = uart_done;
    ferr_prev = frame_err;
  end

  task automatic hold(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CYC);
    hold(stop_v, stop_len);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_ok;
    int         idle;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    int nd, ne, n;
    logic [7:0] prev_data;
    logic       busy_all;
    logic [7:0] exp_q[$];
    int         exp_err;

    tbl[0] = '{8'hA5, 1'b1, 15, 1, 0, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 10, 1, 0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 10, 1, 0, 8'hFF};
    tbl[3] = '{8'h55, 1'b0, 10, 0, 1, 8'hFF};
    tbl[4] = '{8'h81, 1'b1, 12, 1, 0, 8'h81};
    tbl[5] = '{8'h7E, 1'b0, 10, 0, 1, 8'h81};

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_done", uart_done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_data", uart_data, 8'h00);
    sys_rst_n = 1'b1;
    hold(1'b1, 5);

    // Directed vector table
    for (int t = 0; t < 6; t++) begin
      nd = obs_q.size();
      ne = err_cnt;
      send_frame(tbl[t].b, tbl[t].stop_ok, BIT_CYC);
      hold(1'b1, tbl[t].idle);
      check("tbl_done_cnt", obs_q.size() - nd, tbl[t].exp_done);
      check("tbl_err_cnt", err_cnt - ne, tbl[t].exp_err);
      check("tbl_data", uart_data, tbl[t].exp_data);
      check("tbl_busy_idle", rx_busy, 1'b0);
    end

    // Back-to-back frames, no idle bits
    nd = obs_q.size();
    send_frame(8'h3C, 1'b1, BIT_CYC);
    send_frame(8'hC3, 1'b1, BIT_CYC);
    hold(1'b1, 20);
    check("b2b_done_cnt", obs_q.size() - nd, 2);
    if (obs_q.size() >= nd + 2) begin
      check("b2b_first", obs_q[nd], 8'h3C);
      check("b2b_second", obs_q[nd+1], 8'hC3);
      check("b2b_spacing", obs_cyc_q[nd+1] - obs_cyc_q[nd], 100);
    end

    // Short low glitch on an idle line
    nd = obs_q.size();
    ne = err_cnt;
    hold(1'b0, 3);
    uart_rxd = 1'b1;
    check("glitch_busy_set", rx_busy, 1'b1);
    n = 0;
    while (rx_busy && n < 12) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("glitch_busy_clear", (n <= 7), 1'b1);
    hold(1'b1, 20);
    check("glitch_no_done", obs_q.size() - nd, 0);
    check("glitch_no_ferr", err_cnt - ne, 0);

    // Low stop bit held low for 30 cycles
    prev_data = uart_data;
    nd = obs_q.size();
    ne = err_cnt;
    send_frame(8'h55, 1'b0, 0);
    busy_all = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk);
      #1;
      busy_all &= rx_busy;
    end
    check("break_busy_held", busy_all, 1'b1);
    uart_rxd = 1'b1;
    n = 0;
    while (rx_busy && n < 10) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("break_busy_clear", rx_busy, 1'b0);
    hold(1'b1, 10);
    check("break_ferr_cnt", err_cnt - ne, 1);
    check("break_no_done", obs_q.size() - nd, 0);
    check("break_data_kept", uart_data, prev_data);

    // Reset during data bit 4 of 8'hFF
    nd = obs_q.size();
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT_CYC);
    hold(1'b1, 5);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    check("midrst_done", uart_done, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_busy", rx_busy, 1'b0);
    check("midrst_data", uart_data, 8'h00);
    hold(1'b1, 2);
    sys_rst_n = 1'b1;
    hold(1'b1, 40);
    check("midrst_no_done", obs_q.size() - nd, 0);
    send_frame(8'h12, 1'b1, BIT_CYC);
    hold(1'b1, 10);
    check("midrst_next_data", uart_data, 8'h12);
    check("midrst_next_cnt", obs_q.size() - nd, 1);

    // Reset released while the line is low mid-frame: the partial frame must be ignored
    nd = obs_q.size();
    ne = err_cnt;
    hold(1'b0, BIT_CYC * 5 - 5);
    sys_rst_n = 1'b0;
    hold(1'b0, 3);
    sys_rst_n = 1'b1;
    hold(1'b0, 5 + BIT_CYC * 3);
    hold(1'b1, 30);
    check("lowrel_no_done", obs_q.size() - nd, 0);
    check("lowrel_no_ferr", err_cnt - ne, 0);
    send_frame(8'h5A, 1'b1, BIT_CYC);
    hold(1'b1, 10);
    check("lowrel_next_data", uart_data, 8'h5A);

`ifdef UART_RECV_MAJORITY_EN
    // One-cycle inverted spike at each nominal sample point; the vote must reject it
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h81, 1'b0};
      nd = obs_q.size();
      for (int i = 0; i < 10; i++) begin
        hold(fr[i], 6);
        hold(~fr[i], 1);
        hold(fr[i], 3);
      end
      hold(1'b1, 10);
      check("maj_done_cnt", obs_q.size() - nd, 1);
      check("maj_data", uart_data, 8'h81);
    end
`endif

    // Random frames against a frame-level model: good stop delivers the byte, bad stop only flags an error
    nd = obs_q.size();
    ne = err_cnt;
    exp_err = 0;
    for (int k = 0; k < 25; k++) begin
      logic [7:0] b;
      logic       ok;
      int         gap;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      gap = ok ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 15));
      send_frame(b, ok, BIT_CYC);
      if (gap > 0) hold(1'b1, gap);
      if (ok) exp_q.push_back(b);
      else    exp_err++;
    end
    hold(1'b1, 20);
    check("rand_done_cnt", obs_q.size() - nd, exp_q.size());
    check("rand_err_cnt", err_cnt - ne, exp_err);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (nd + k < obs_q.size()) check("rand_byte", obs_q[nd+k], exp_q[k]);
    end
    if (exp_q.size() > 0) check("rand_last_data", uart_data, exp_q[exp_q.size()-1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
